// File: rtl/vga_sync_porch.sv
// Re-times an upstream VGA stream: counters restart on VSync rise, porches and
// active-low syncs come from the counters, and video is blanked until the stream locks.
module vga_sync_porch #(
  parameter int VIDEO_WIDTH      = 3,
  parameter int TOTAL_COLS       = 800,
  parameter int TOTAL_ROWS       = 525,
  parameter int ACTIVE_COLS      = 640,
  parameter int ACTIVE_ROWS      = 480,
  parameter int FRONT_PORCH_HORZ = 16,
  parameter int BACK_PORCH_HORZ  = 48,
  parameter int FRONT_PORCH_VERT = 10,
  parameter int BACK_PORCH_VERT  = 33
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_L,
  input  logic                   i_HSync,
  input  logic                   i_VSync,
  input  logic [VIDEO_WIDTH-1:0] i_Red_Video,
  input  logic [VIDEO_WIDTH-1:0] i_Grn_Video,
  input  logic [VIDEO_WIDTH-1:0] i_Blu_Video,
  output logic                   o_HSync,
  output logic                   o_VSync,
  output logic [VIDEO_WIDTH-1:0] o_Red_Video,
  output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
  output logic [VIDEO_WIDTH-1:0] o_Blu_Video,
  output logic                   o_Locked,
  output logic                   o_Frame_Err
);

  localparam int CW = 10;

  localparam logic [CW-1:0] COL_LAST = CW'(TOTAL_COLS - 1);
  localparam logic [CW-1:0] ROW_LAST = CW'(TOTAL_ROWS - 1);
  localparam logic [CW-1:0] ACT_COLS = CW'(ACTIVE_COLS);
  localparam logic [CW-1:0] ACT_ROWS = CW'(ACTIVE_ROWS);
  localparam logic [CW-1:0] HS_FIRST = CW'(ACTIVE_COLS + FRONT_PORCH_HORZ);
  localparam logic [CW-1:0] HS_LAST  = CW'(TOTAL_COLS - BACK_PORCH_HORZ - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(ACTIVE_ROWS + FRONT_PORCH_VERT);
  localparam logic [CW-1:0] VS_LAST  = CW'(TOTAL_ROWS - BACK_PORCH_VERT - 1);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } lock_state_e;

  // Upstream horizontal sync carries no information the counters lack.
  logic unused_hsync;
  assign unused_hsync = i_HSync;

  logic                   vsync_in_q;
  logic                   frame_start;
  logic                   expected_wrap;
  logic [CW-1:0]          col_q, col_d;
  logic [CW-1:0]          row_q, row_d;
  logic [VIDEO_WIDTH-1:0] red_q, grn_q, blu_q;
  logic                   hsync_out_q, hsync_out_d;
  logic                   vsync_out_q, vsync_out_d;
  logic [VIDEO_WIDTH-1:0] red_out_q, red_out_d;
  logic [VIDEO_WIDTH-1:0] grn_out_q, grn_out_d;
  logic [VIDEO_WIDTH-1:0] blu_out_q, blu_out_d;
  lock_state_e            state_q, state_d;
  logic                   locked_q, locked_d;
  logic                   frame_err_q, frame_err_d;
  logic                   in_active;

  assign frame_start   = i_VSync & ~vsync_in_q;
  assign expected_wrap = (col_q == COL_LAST) && (row_q == ROW_LAST);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      vsync_in_q <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      red_q      <= '0;
      grn_q      <= '0;
      blu_q      <= '0;
    end else begin
      vsync_in_q <= i_VSync;
      col_q      <= col_d;
      row_q      <= row_d;
      red_q      <= i_Red_Video;
      grn_q      <= i_Grn_Video;
      blu_q      <= i_Blu_Video;
    end
  end

  // Free-running raster position; a frame start snaps it back to the origin.
  always_comb begin
    col_d = col_q + 10'd1;
    row_d = row_q;
    if (col_q == COL_LAST) begin
      col_d = '0;
      row_d = (row_q == ROW_LAST) ? '0 : row_q + 10'd1;
    end
    if (frame_start) begin
      col_d = '0;
      row_d = '0;
    end
  end

  assign in_active = (col_q < ACT_COLS) && (row_q < ACT_ROWS);

  always_comb begin
    hsync_out_d = ~((col_q >= HS_FIRST) && (col_q <= HS_LAST));
    vsync_out_d = ~((row_q >= VS_FIRST) && (row_q <= VS_LAST));
    red_out_d   = (in_active && locked_q) ? red_q : '0;
    grn_out_d   = (in_active && locked_q) ? grn_q : '0;
    blu_out_d   = (in_active && locked_q) ? blu_q : '0;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      hsync_out_q <= 1'b1;
      vsync_out_q <= 1'b1;
      red_out_q   <= '0;
      grn_out_q   <= '0;
      blu_out_q   <= '0;
    end else begin
      hsync_out_q <= hsync_out_d;
      vsync_out_q <= vsync_out_d;
      red_out_q   <= red_out_d;
      grn_out_q   <= grn_out_d;
      blu_out_q   <= blu_out_d;
    end
  end

  // Lock FSM: state register
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q     <= ST_UNLOCKED;
      locked_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      locked_q    <= locked_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Lock FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_UNLOCKED: if (frame_start) state_d = ST_ACQUIRE;
      ST_ACQUIRE:  if (frame_start && expected_wrap) state_d = ST_LOCKED;
      ST_LOCKED:   if (frame_start != expected_wrap) state_d = ST_ACQUIRE;
      default:     state_d = ST_UNLOCKED;
    endcase
  end

  // Lock FSM: outputs, registered one cycle after the deciding FS/EW cycle
  always_comb begin
    locked_d    = (state_d == ST_LOCKED);
    frame_err_d = 1'b0;
    case (state_q)
      ST_ACQUIRE: frame_err_d = frame_start && !expected_wrap;
      ST_LOCKED:  frame_err_d = frame_start != expected_wrap;
      default:    frame_err_d = 1'b0;
    endcase
  end

  assign o_HSync     = hsync_out_q;
  assign o_VSync     = vsync_out_q;
  assign o_Red_Video = red_out_q;
  assign o_Grn_Video = grn_out_q;
  assign o_Blu_Video = blu_out_q;
  assign o_Locked    = locked_q;
  assign o_Frame_Err = frame_err_q;

endmodule

// File: tb/tb_vga_sync_porch.sv
// Bench for vga_sync_porch on a shrunken raster: an upstream generator drives frames
// (normal, short, suppressed, glitched, reset mid-line) and a raster-position model predicts outputs.
module tb_vga_sync_porch;

  localparam int VW  = 3;
  localparam int TC  = 20;
  localparam int TR  = 13;
  localparam int AC  = 12;
  localparam int AR  = 8;
  localparam int FPH = 2;
  localparam int BPH = 3;
  localparam int FPV = 1;
  localparam int BPV = 2;
  localparam int W   = 2 + 3 * VW + 2;

  logic          clk;
  logic          rst_n;
  logic          hs_in;
  logic          vs_in;
  logic [VW-1:0] r_in, g_in, b_in;
  logic          o_hs, o_vs, o_locked, o_err;
  logic [VW-1:0] o_r, o_g, o_b;

  vga_sync_porch #(
    .VIDEO_WIDTH(VW), .TOTAL_COLS(TC), .TOTAL_ROWS(TR),
    .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
    .FRONT_PORCH_HORZ(FPH), .BACK_PORCH_HORZ(BPH),
    .FRONT_PORCH_VERT(FPV), .BACK_PORCH_VERT(BPV)
  ) dut (
    .i_Clk(clk), .i_Rst_L(rst_n),
    .i_HSync(hs_in), .i_VSync(vs_in),
    .i_Red_Video(r_in), .i_Grn_Video(g_in), .i_Blu_Video(b_in),
    .o_HSync(o_hs), .o_VSync(o_vs),
    .o_Red_Video(o_r), .o_Grn_Video(o_g), .o_Blu_Video(o_b),
    .o_Locked(o_locked), .o_Frame_Err(o_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // model state: cycles since the raster origin, last VSync, last pixel, lock phase
  int          m_n;
  logic        m_vs_prev;
  logic [VW-1:0] m_pr, m_pg, m_pb;
  int          m_phase;  // 0 unlocked, 1 acquiring, 2 locked

  logic [W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_n       = 0;
    m_vs_prev = 1'b0;
    m_pr      = '0;
    m_pg      = '0;
    m_pb      = '0;
    m_phase   = 0;
    exp_q.delete();
    exp_q.push_back({1'b1, 1'b1, {(3*VW){1'b0}}, 1'b0, 1'b0});
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_hs"}, 16'(o_hs), 16'd1);
    check_eq({tag, "_vs"}, 16'(o_vs), 16'd1);
    check_eq({tag, "_video"}, 16'({o_r, o_g, o_b}), 16'd0);
    check_eq({tag, "_lock"}, 16'(o_locked), 16'd0);
    check_eq({tag, "_err"}, 16'(o_err), 16'd0);
  endtask

  // Called at a falling edge: checks the current outputs, applies one input cycle,
  // predicts the outputs after the coming rising edge, then waits one clock.
  task automatic drive_cycle(input logic vs, input logic hs,
                             input logic [VW-1:0] r, input logic [VW-1:0] g, input logic [VW-1:0] b);
    logic [W-1:0] e;
    int   col, row, nxt;
    logic fs, ew, err, vid_on, hs_e, vs_e;
    if (exp_q.size() == 0) begin
      check_eq("exp_queue_empty", 16'd1, 16'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq("sync", 16'({o_hs, o_vs}), 16'(e[W-1 -: 2]));
      check_eq("video", 16'({o_r, o_g, o_b}), 16'(e[W-3 -: 3*VW]));
      check_eq("lock", 16'(o_locked), 16'(e[1]));
      check_eq("frame_err", 16'(o_err), 16'(e[0]));
    end
    vs_in = vs;
    hs_in = hs;
    r_in  = r;
    g_in  = g;
    b_in  = b;

    col    = m_n % TC;
    row    = (m_n / TC) % TR;
    hs_e   = !(col >= AC + FPH && col <= TC - BPH - 1);
    vs_e   = !(row >= AR + FPV && row <= TR - BPV - 1);
    vid_on = (col < AC) && (row < AR) && (m_phase == 2);
    fs     = vs && !m_vs_prev;
    ew     = (col == TC - 1) && (row == TR - 1);
    nxt    = m_phase;
    err    = 1'b0;
    if (m_phase == 0) begin
      if (fs) nxt = 1;
    end else if (m_phase == 1) begin
      if (fs && ew) nxt = 2;
      else if (fs) err = 1'b1;
    end else begin
      if (fs != ew) begin
        nxt = 1;
        err = 1'b1;
      end
    end
    exp_q.push_back({hs_e, vs_e,
                     vid_on ? m_pr : {VW{1'b0}},
                     vid_on ? m_pg : {VW{1'b0}},
                     vid_on ? m_pb : {VW{1'b0}},
                     (nxt == 2), err});
    m_n       = fs ? 0 : (m_n + 1) % (TC * TR);
    m_vs_prev = vs;
    m_pr      = r;
    m_pg      = g;
    m_pb      = b;
    m_phase   = nxt;
    @(negedge clk);
  endtask

  // One upstream frame of 'rows' lines; optional VSync suppression, random VSync
  // glitches, and an early stop after 'stop_after' cycles (negative = full frame).
  task automatic run_frame(input int rows, input bit kill_vs, input bit glitch, input int stop_after);
    int k;
    logic vs;
    logic [VW-1:0] r;
    k = 0;
    for (int row = 0; row < rows; row++) begin
      for (int col = 0; col < TC; col++) begin
        if (stop_after >= 0 && k >= stop_after) return;
        vs = (row < AR) && !kill_vs;
        if (glitch && $urandom_range(0, 99) == 0) vs = ~vs;
        r = VW'($urandom_range(0, (1 << VW) - 1));
        if ((row == 0 && col == 0) || col == AC) r = 3'd7;
        drive_cycle(vs, (col < AC), r,
                    VW'($urandom_range(0, (1 << VW) - 1)),
                    VW'($urandom_range(0, (1 << VW) - 1)));
        k++;
      end
    end
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    rst_n = 1'b1;
    hs_in = 1'b0;
    vs_in = 1'b0;
    r_in  = '0;
    g_in  = '0;
    b_in  = '0;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("por");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // random phase before the first frame, then acquire and hold lock
    run_idle($urandom_range(0, 50));
    for (int f = 0; f < 4; f++) run_frame(TR, 1'b0, 1'b0, -1);

    // early VSync rise (short frame), then recovery
    run_frame(TR - 1, 1'b0, 1'b0, -1);
    for (int f = 0; f < 3; f++) run_frame(TR, 1'b0, 1'b0, -1);

    // one VSync rise suppressed, then recovery
    run_frame(TR, 1'b1, 1'b0, -1);
    for (int f = 0; f < 3; f++) run_frame(TR, 1'b0, 1'b0, -1);

    // random VSync glitches, then recovery
    run_frame(TR, 1'b0, 1'b1, -1);
    run_frame(TR, 1'b0, 1'b1, -1);
    for (int f = 0; f < 3; f++) run_frame(TR, 1'b0, 1'b0, -1);

    // asynchronous reset mid-line while locked
    run_frame(TR, 1'b0, 1'b0, 2 * TC + 7);
    check_eq("pre_reset_locked_model", 16'(o_locked), 16'(m_phase == 2));
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    repeat (2) @(negedge clk);
    check_reset_outputs("held_rst");
    rst_n = 1'b1;
    model_reset();
    run_idle($urandom_range(0, 30));
    for (int f = 0; f < 4; f++) run_frame(TR, 1'b0, 1'b0, -1);
    check_eq("relock_after_reset", 16'(o_locked), 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
